// File: rtl/thermometer_pkg.sv
// thermometer_pkg
//
// Definitions shared by the thermometer encoder and decoder blocks: the
// default code width and the three-state scan sequence used by the
// sequential decoder.
//
// Contents:
//   K_DEF   : default binary width of a decoded count
//   W_DEF   : default thermometer width, always 2^K_DEF - 1
//   state_e : decoder sequence IDLE -> SCAN -> DONE
package thermometer_pkg;

    localparam int K_DEF = 3;
    localparam int W_DEF = (1 << K_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/thermometer_decoder_seq.sv
// thermometer_decoder_seq
//
// Sequential thermometer-to-binary decoder. One W-bit thermometer word is
// accepted through a valid/ready handshake, then walked one bit per clock
// from bit 0 upward. The result is the count of contiguous ones starting at
// bit 0 (the index of the first zero, or W if there is none), together with
// a bubble flag that is raised when any one sits above a zero.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  t holds a word to decode
//   in_ready   out  1  block can accept a word (only while idle)
//   t          in   W  thermometer word, bit 0 is the lowest level
//   out_valid  out  1  q/err hold a finished result
//   out_ready  in   1  downstream consumes the result
//   q          out  K  decoded count
//   err        out  1  bubble detected
module thermometer_decoder_seq
    import thermometer_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] t,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] q,
    output logic         err
);

    // A count of up to W ones must fit exactly in K bits, and the scan index
    // reuses the same K-bit width, so the two parameters have to agree.
    generate
        if (W != (1 << K) - 1) begin : gWidthCheck
            $error("thermometer_decoder_seq: W must equal 2^K - 1");
        end
    endgenerate

    localparam logic [K-1:0] LAST_IDX = K'(W - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   word_q, word_d;
    logic [K-1:0]   idx_q, idx_d;
    logic [K-1:0]   cnt_q, cnt_d;
    logic           seenZero_q, seenZero_d;
    logic           errAcc_q, errAcc_d;
    logic [K-1:0]   result_q, result_d;
    logic           errOut_q, errOut_d;
    logic           curBit;

    // Handshake outputs depend on state alone so neither side sees a
    // combinational path from the other.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = result_q;
    assign err       = errOut_q;

    assign curBit = word_q[idx_q];

    // Next-state and datapath update. During the scan, ones only count while
    // no zero has been seen yet, so q stays equal to the index of the first
    // zero even when a bubble is present. The final bit's contribution is
    // folded in on the same edge that publishes the result, which is why the
    // result is taken from cnt_d and errAcc_d rather than from the registers.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        seenZero_d = seenZero_q;
        errAcc_d   = errAcc_q;
        result_d   = result_q;
        errOut_d   = errOut_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d     = t;
                    idx_d      = '0;
                    cnt_d      = '0;
                    seenZero_d = 1'b0;
                    errAcc_d   = 1'b0;
                    state_d    = SCAN;
                end
            end

            SCAN: begin
                if (curBit && !seenZero_q) begin
                    cnt_d = cnt_q + K'(1);
                end else if (!curBit) begin
                    seenZero_d = 1'b1;
                end else begin
                    errAcc_d = 1'b1;
                end

                if (idx_q == LAST_IDX) begin
                    result_d = cnt_d;
                    errOut_d = errAcc_d;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + K'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset abandons any word in flight and clears every
    // register, including the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            seenZero_q <= 1'b0;
            errAcc_q   <= 1'b0;
            result_q   <= '0;
            errOut_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            seenZero_q <= seenZero_d;
            errAcc_q   <= errAcc_d;
            result_q   <= result_d;
            errOut_q   <= errOut_d;
        end
    end

endmodule

// File: tb/tb_thermometer_decoder_seq.sv
// tb_thermometer_decoder_seq
//
// Bench for the sequential thermometer decoder. Expected results come from
// a reference that reads the decode rules directly: q is the position of the
// lowest zero (W when the word is all ones), err is set when a one appears
// anywhere above that zero.
module tb_thermometer_decoder_seq;
    import thermometer_pkg::*;

    localparam int K = K_DEF;
    localparam int W = W_DEF;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] t;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] q;
    logic         err;

    int compareCount;
    int mismatchCount;

    thermometer_decoder_seq #(.K(K), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .t         (t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .err       (err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Last-resort guard so the run always ends even if a bounded loop is
    // somehow bypassed.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed != expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: scan for the lowest zero, then look for any one above it.
    task automatic modelDecode(input logic [W-1:0] word, output int expQ, output int expErr);
        bit foundZero;
        expQ      = W;
        expErr    = 0;
        foundZero = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!foundZero && !word[i]) begin
                expQ      = i;
                foundZero = 1'b1;
            end else if (foundZero && word[i]) begin
                expErr = 1;
            end
        end
    endtask

    // Wait (bounded) until the block is ready for a new word.
    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        checkOutput({tag, "_idle"}, int'(in_ready), 1);
    endtask

    // Count clocks after acceptance until out_valid, bounded.
    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Send one word, check latency and result, hold the result under
    // backpressure for 'hold' cycles, then consume it.
    task automatic applyStimulus(input string tag, input logic [W-1:0] word, input int hold);
        int expQ;
        int expErr;
        int lat;
        modelDecode(word, expQ, expErr);
        waitIdle(tag);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        t         = word;
        tick();
        in_valid  = 1'b0;
        t         = W'($urandom);
        checkOutput({tag, "_in_ready_drop"}, int'(in_ready), 0);
        waitResult(lat);
        checkOutput({tag, "_latency"}, lat, W);
        checkOutput({tag, "_q"}, int'(q), expQ);
        checkOutput({tag, "_err"}, int'(err), expErr);
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput({tag, "_hold_valid"}, int'(out_valid), 1);
            checkOutput({tag, "_hold_q"}, int'(q), expQ);
            checkOutput({tag, "_hold_err"}, int'(err), expErr);
            checkOutput({tag, "_hold_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_consumed_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_consumed_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        logic [W-1:0] word;
        int n;

        compareCount  = 0;
        mismatchCount = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        t         = '0;

        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_q", int'(q), 0);
        checkOutput("reset_err", int'(err), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);

        // Directed cases: basic, extremes, bubbles, backpressure.
        applyStimulus("basic", 7'b0000111, 0);
        applyStimulus("zeros", 7'b0000000, 0);
        applyStimulus("ones", 7'b1111111, 1);
        applyStimulus("bubble_a", 7'b0001011, 5);
        applyStimulus("bubble_b", 7'b1111110, 2);

        // Busy ignore: a second word held valid during the scan must not
        // disturb the first, and is only taken once the block is idle again.
        waitIdle("busy");
        in_valid = 1'b1;
        t        = 7'b0000011;
        tick();
        t        = 7'b0111111;
        checkOutput("busy_in_ready_drop", int'(in_ready), 0);
        waitResult(lat);
        checkOutput("busy_latency_a", lat, W);
        checkOutput("busy_q_a", int'(q), 2);
        checkOutput("busy_err_a", int'(err), 0);
        out_ready = 1'b1;
        tick();
        checkOutput("busy_consume_valid", int'(out_valid), 0);
        checkOutput("busy_consume_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        checkOutput("busy_accept_b", int'(in_ready), 0);
        waitResult(lat);
        checkOutput("busy_latency_b", lat, W);
        checkOutput("busy_q_b", int'(q), 6);
        checkOutput("busy_err_b", int'(err), 0);
        tick();
        out_ready = 1'b0;
        checkOutput("busy_final_in_ready", int'(in_ready), 1);

        // Reset while bit 3 is being scanned.
        waitIdle("rst_mid");
        in_valid = 1'b1;
        t        = 7'b0011111;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_mid_out_valid", int'(out_valid), 0);
        checkOutput("rst_mid_q", int'(q), 0);
        checkOutput("rst_mid_err", int'(err), 0);
        checkOutput("rst_mid_in_ready", int'(in_ready), 1);
        applyStimulus("after_rst", 7'b0000001, 0);

        // Random words: half clean thermometer codes, half with a flipped bit.
        for (int i = 0; i < 24; i++) begin
            n    = $urandom_range(0, W);
            word = W'((1 << n) - 1);
            if ($urandom_range(0, 1) == 1) begin
                word[$urandom_range(0, W - 1)] ^= 1'b1;
            end
            applyStimulus("random", word, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/thermometer_decoder_seq.md
# thermometer_decoder_seq

Sequential thermometer-to-binary decoder: the receiving end of the thermometer code produced by the team's encoder. It accepts one W-bit thermometer word through a valid/ready handshake and scans it one bit per clock, while-loop style. It returns the K-bit count of contiguous ones from bit 0, plus a bubble-error flag. It sits between any thermometer-coded source (comparator bank, level meter) and binary datapath logic.

## Interface

**Parameters**
- `K`, 3, binary output width
- `W`, 7, thermometer input width; must equal 2^K − 1

**Ports** (clock and reset first)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  `t` holds a word to decode
- `in_ready`  out  1  block can accept a word (high only in IDLE)
- `t`  in  W  thermometer input word; bit 0 is the lowest level
- `out_valid`  out  1  `q`/`err` hold a finished result
- `out_ready`  in  1  downstream consumes the result
- `q`  out  K  decoded count
- `err`  out  1  bubble detected (a 1 above a 0)

## Operation

- **FSM states:** IDLE, SCAN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `t` into an internal W-bit register; clear `idx`, count, `seen_zero` and `err_acc`; go to SCAN.
  - `in_valid` while not in IDLE is ignored; the word is not latched.
- **SCAN:** on each edge, examine captured bit `idx`:
  - bit=1 and `seen_zero`=0: count += 1.
  - bit=0: set `seen_zero`.
  - bit=1 and `seen_zero`=1: set `err_acc`; count is unchanged.
  - When `idx`==W−1: load `q`←count and `err`←`err_acc`, then go to DONE. Otherwise `idx` += 1.
- **DONE**
  - `out_valid`=1.
  - `q` and `err` hold stable until `out_valid`&&`out_ready`; then go to IDLE.
- **Arithmetic and result rules**
  - Count width is K. The maximum value is W = 2^K − 1, so no overflow is possible.
  - `q` is always the index of the first 0, or W if there is none. This holds even when `err`=1.
  - All-zero input gives `q`=0. All-ones input gives `q`=W.
- **Reset**
  - `rst` high at any edge, including mid-SCAN or in DONE, abandons the current word.
  - State goes to IDLE; `q`=0, `err`=0, `out_valid`=0, `in_ready`=1 after that edge.
  - All internal registers are cleared.

## Timing

- **Output reset values:** `q`=0, `err`=0, `out_valid`=0, `in_ready`=1.
- **Latency**
  - Accept edge E0. SCAN edges E1..EW process bits 0..W−1.
  - `out_valid` is high from edge EW.
  - Result latency is W cycles after acceptance (7 for the defaults).
- **Handshake timing**
  - `in_ready` is a pure function of state and drops the cycle after acceptance.
  - On the consume edge, `out_valid` falls and `in_ready` rises; both change at that edge.
  - A new word can be accepted on the next edge at the earliest.
- **Throughput:** one word per W+2 cycles with `out_ready` held high.
- **Backpressure:** with `out_ready` low, the block holds DONE indefinitely with stable outputs.
- **Simultaneous events**
  - `rst` overrides any handshake on the same edge.
  - `in_valid` in DONE during the consume edge is not accepted; acceptance requires IDLE.

## Structure

- **Shared package `thermometer_pkg`:**
  - default `K` and `W` constants, shared with the encoder;
  - state enum {IDLE, SCAN, DONE}.
- **Single module, no sub-module.** The scan datapath is a bit counter, an index counter and two flags.
- **Elaboration check:** a compile-time check rejects W ≠ 2^K − 1.

## Test plan

- **Basic decode:** `t`=7'b0000111, `in_valid` 1 cycle, `out_ready`=1. Required: `out_valid` 7 cycles after accept, `q`=3, `err`=0, `in_ready` high the following cycle.
- **Extremes:** `t`=7'b0000000 gives `q`=0, `err`=0. `t`=7'b1111111 gives `q`=7, `err`=0.
- **Bubble:** `t`=7'b0001011 gives `q`=2, `err`=1. `t`=7'b1111110 gives `q`=0, `err`=1.
- **Backpressure:** `out_ready` low for 5 cycles after `out_valid`. Required: `q`/`err`/`out_valid` stay constant and `in_ready`=0 throughout; release consumes in 1 cycle and the block returns to IDLE.
- **Busy ignore:** `in_valid` with a different `t` held high during SCAN. Required: the result reflects only the first word, and the second word is accepted only once back in IDLE.
- **Reset mid-scan:** assert `rst` at SCAN bit 3 of `t`=7'b0011111. Required: next cycle IDLE with `out_valid`=0, `q`=0, `err`=0, `in_ready`=1. A following `t`=7'b0000001 decodes to `q`=1.
